// File: rtl/reset_sequencer.sv
// Ordered reset release for downstream subsystems: one stage at a time, lowest index first,
// each stage waiting for its ready acknowledge (with timeout) before the next is released.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 1000,
  parameter int DEBOUNCE    = 50000,
  parameter int ACK_TIMEOUT = 100000,
  parameter int CNT_W       = 20
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iPOR_DONE,
  input  logic                  iKEY_N,
  input  logic [NUM_STAGES-1:0] iSTAGE_ACK,
  output logic [NUM_STAGES-1:0] oSTAGE_RESET,
  output logic                  oALL_READY,
  output logic                  oFAULT,
  output logic [2:0]            oSTATE
);

  // state    | meaning
  // HOLD     | all stages held in reset, waiting for POR done and button released
  // DELAY    | counting hold time before releasing stage k
  // WAIT_ACK | stage k released, waiting for its acknowledge
  // RUN      | every stage released and acknowledged
  // FAULT    | an acknowledge timed out; all stages held until a button press
  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_DELAY    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_FAULT    = 3'd4
  } state_e;

  localparam int K_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_STAGES - 1);

  logic            key_s1_q, key_s2_q;
  logic            db_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            btn_held;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [K_W-1:0]          k_q, k_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic                    fault_q, fault_d;

  // The debounced level only flips after DEBOUNCE consecutive opposite samples.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      key_s1_q <= iKEY_N;
      key_s2_q <= key_s1_q;
      if (key_s2_q == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_q     <= key_s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  assign btn_held = ~db_q;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    fault_d = fault_q;
    // A POR drop alone does not pull the sequencer out of FAULT; only the button does.
    if (btn_held || (!iPOR_DONE && state_q != S_FAULT)) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      k_d     = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (btn_held) fault_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            rst_d[k_q] = 1'b0;
            cnt_d      = '0;
            state_d    = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_ACK: begin
          if (iSTAGE_ACK[k_q]) begin
            if (k_q == K_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              k_d     = k_q + K_W'(1);
              cnt_d   = '0;
              state_d = S_DELAY;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            rst_d   = '1;
            ready_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_RUN: begin
          ready_d = 1'b1;
        end
        S_FAULT: begin
          rst_d   = '1;
          ready_d = 1'b0;
          fault_d = 1'b1;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      k_q     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign oSTAGE_RESET = rst_q;
  assign oALL_READY   = ready_q;
  assign oFAULT       = fault_q;
  assign oSTATE       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: nominal sequencing, pre-asserted acks, timeout,
// fault recovery, button debounce in RUN, and POR abort racing an acknowledge.
module tb_reset_sequencer;

  localparam int NS = 3;

  logic          iCLK;
  logic          iRST;
  logic          iPOR_DONE;
  logic          iKEY_N;
  logic [NS-1:0] iSTAGE_ACK;
  logic [NS-1:0] oSTAGE_RESET;
  logic          oALL_READY;
  logic          oFAULT;
  logic [2:0]    oSTATE;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] ST_HOLD = 3'd0, ST_DELAY = 3'd1, ST_WAIT = 3'd2,
                         ST_RUN = 3'd3, ST_FAULT = 3'd4;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .STAGE_DELAY(4),
    .DEBOUNCE   (3),
    .ACK_TIMEOUT(8),
    .CNT_W      (20)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iPOR_DONE   (iPOR_DONE),
    .iKEY_N      (iKEY_N),
    .iSTAGE_ACK  (iSTAGE_ACK),
    .oSTAGE_RESET(oSTAGE_RESET),
    .oALL_READY  (oALL_READY),
    .oFAULT      (oFAULT),
    .oSTATE      (oSTATE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // Entered just after the edge that put the FSM in DELAY for stage k.
  task automatic run_stage(input int k);
    logic [2:0] pre, post;
    pre  = 3'b111 << k;
    post = 3'b111 << (k + 1);
    step(3);
    check("stage_held", oSTAGE_RESET, pre);
    check("state_delay", oSTATE, ST_DELAY);
    step(1);
    check("stage_rel", oSTAGE_RESET, post);
    check("state_wait", oSTATE, ST_WAIT);
    step(2);
    check("wait_no_ack", oSTATE, ST_WAIT);
    check("ready_early", oALL_READY, 1'b0);
    iSTAGE_ACK[k] = 1'b1;
    step(1);
    check("after_ack", oSTATE, (k == NS - 1) ? ST_RUN : ST_DELAY);
    check("ready_ack", oALL_READY, (k == NS - 1) ? 1'b1 : 1'b0);
  endtask

  initial begin
    logic [2:0] exp_rst;
    iRST       = 1'b1;
    iPOR_DONE  = 1'b0;
    iKEY_N     = 1'b1;
    iSTAGE_ACK = '0;
    step(1);
    iRST = 1'b0;
    check("rst_state", oSTATE, ST_HOLD);
    check("rst_stages", oSTAGE_RESET, 3'b111);
    check("rst_ready", oALL_READY, 1'b0);
    check("rst_fault", oFAULT, 1'b0);

    // Nominal power-up
    step(10);
    check("por_wait_state", oSTATE, ST_HOLD);
    check("por_wait_stages", oSTAGE_RESET, 3'b111);
    iPOR_DONE = 1'b1;
    step(1);
    check("leave_hold", oSTATE, ST_DELAY);
    for (int k = 0; k < NS; k++) run_stage(k);

    // Pre-asserted acks: releases at +4, +9, +14, ready at +15
    iPOR_DONE  = 1'b0;
    iSTAGE_ACK = '1;
    step(1);
    check("abort_state", oSTATE, ST_HOLD);
    check("abort_out", {oALL_READY, oSTAGE_RESET}, 4'b0111);
    iPOR_DONE = 1'b1;
    step(1);
    check("pre_leave_hold", oSTATE, ST_DELAY);
    for (int i = 1; i <= 15; i++) begin
      step(1);
      exp_rst = (i < 4) ? 3'b111 : (i < 9) ? 3'b110 : (i < 14) ? 3'b100 : 3'b000;
      check("pre_ack_seq", {oALL_READY, oSTAGE_RESET}, {(i >= 15), exp_rst});
    end

    // Timeout on stage 1
    iPOR_DONE  = 1'b0;
    iSTAGE_ACK = '0;
    step(1);
    check("to_hold", oSTATE, ST_HOLD);
    iPOR_DONE = 1'b1;
    step(1);
    step(4);
    check("to_rel0", oSTAGE_RESET, 3'b110);
    iSTAGE_ACK = 3'b001;
    step(1);
    check("to_delay1", oSTATE, ST_DELAY);
    step(4);
    check("to_rel1", oSTAGE_RESET, 3'b100);
    check("to_wait1", oSTATE, ST_WAIT);
    step(7);
    check("to_not_yet", oSTATE, ST_WAIT);
    check("to_no_fault", oFAULT, 1'b0);
    step(1);
    check("to_fault", oFAULT, 1'b1);
    check("to_stages", oSTAGE_RESET, 3'b111);
    check("to_state", oSTATE, ST_FAULT);
    step(20);
    check("fault_sticky", oSTATE, ST_FAULT);
    check("fault_sticky_flag", oFAULT, 1'b1);

    // Fault recovery by button press and release
    iKEY_N = 1'b0;
    step(5);
    check("fr_press_pending", oSTATE, ST_FAULT);
    check("fr_fault_pending", oFAULT, 1'b1);
    step(1);
    check("fr_hold", oSTATE, ST_HOLD);
    check("fr_fault_clr", oFAULT, 1'b0);
    check("fr_stages", oSTAGE_RESET, 3'b111);
    iSTAGE_ACK = '0;
    step(4);
    iKEY_N = 1'b1;
    step(5);
    check("fr_release_pending", oSTATE, ST_HOLD);
    step(1);
    check("fr_restart", oSTATE, ST_DELAY);
    for (int k = 0; k < NS; k++) run_stage(k);
    check("fr_fault_low", oFAULT, 1'b0);

    // Button in RUN: 2-cycle glitch ignored, sustained press aborts
    iKEY_N = 1'b0;
    step(2);
    iKEY_N = 1'b1;
    step(8);
    check("glitch_state", oSTATE, ST_RUN);
    check("glitch_out", {oALL_READY, oSTAGE_RESET}, 4'b1000);
    iKEY_N     = 1'b0;
    iSTAGE_ACK = '0;
    step(5);
    check("press_pending", oSTATE, ST_RUN);
    step(1);
    check("press_hold", oSTATE, ST_HOLD);
    check("press_out", {oALL_READY, oSTAGE_RESET}, 4'b0111);
    step(14);
    check("press_held", oSTATE, ST_HOLD);
    iKEY_N = 1'b1;
    step(5);
    check("rel_pending", oSTATE, ST_HOLD);
    step(1);
    check("rel_restart", oSTATE, ST_DELAY);
    for (int k = 0; k < NS; k++) run_stage(k);

    // POR drop coincident with ack[0]: abort wins, k returns to 0
    iPOR_DONE  = 1'b0;
    iSTAGE_ACK = '0;
    step(1);
    iPOR_DONE = 1'b1;
    step(1);
    step(4);
    check("race_wait", oSTATE, ST_WAIT);
    check("race_rel0", oSTAGE_RESET, 3'b110);
    iPOR_DONE  = 1'b0;
    iSTAGE_ACK = 3'b001;
    step(1);
    check("race_hold", oSTATE, ST_HOLD);
    check("race_out", {oALL_READY, oSTAGE_RESET}, 4'b0111);
    iPOR_DONE  = 1'b1;
    iSTAGE_ACK = '0;
    step(1);
    check("race_restart", oSTATE, ST_DELAY);
    step(4);
    check("race_k0", oSTAGE_RESET, 3'b110);

    // Synchronous reset mid-sequence
    iRST = 1'b1;
    step(1);
    check("mid_rst_state", oSTATE, ST_HOLD);
    check("mid_rst_out", {oFAULT, oALL_READY, oSTAGE_RESET}, 5'b00111);
    iRST = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the global power-on release from the board-level power-up delay logic and the user reset push-button.
- Drives NUM_STAGES ordered, active-high reset outputs to downstream subsystems, e.g. SDRAM controller, USB/host interface, Z80 core.
- Releases the stages one at a time, lowest index first. Before moving to the next stage it waits for a per-stage ready acknowledge, with a timeout.
- Sits between the power-up delay logic and all downstream reset inputs.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
STAGE_DELAY, 1000, clock cycles of hold before each stage is released (>=1)
DEBOUNCE, 50000, consecutive synchronized-low cycles needed to register a button press (>=1)
ACK_TIMEOUT, 100000, max cycles to wait for iSTAGE_ACK[k] after releasing stage k (>=1)
CNT_W, 20, width of the shared delay/timeout counter; must hold max(STAGE_DELAY, ACK_TIMEOUT)

Ports:
iCLK  in  1  system clock; all logic on its rising edge
iRST  in  1  reset, synchronous, active-high
iPOR_DONE  in  1  1 = power-on delay complete; level-sensitive, synchronous to iCLK
iKEY_N  in  1  push-button, active-low, asynchronous to iCLK
iSTAGE_ACK  in  NUM_STAGES  per-stage ready; level, synchronous to iCLK
oSTAGE_RESET  out  NUM_STAGES  per-stage reset, active-high
oALL_READY  out  1  1 when every stage is released and acknowledged
oFAULT  out  1  1 when an acknowledge timed out
oSTATE  out  3  current FSM state encoding, for debug

Behaviour:
- Reset values (iRST=1 at a clock edge): state HOLD, oSTAGE_RESET = all ones, oALL_READY=0, oFAULT=0, counter=0, stage index k=0, button synchronizer flops=1, debounced level=1 (released).
- Button path:
  - 2-flop synchronizer on iKEY_N.
  - The debounced level changes only after DEBOUNCE consecutive cycles of the opposite synchronized value.
  - "btn_held" = debounced level is 0.
- FSM states and encodings:
  - HOLD=0: all resets asserted. Go to DELAY when iPOR_DONE=1 and btn_held=0; counter cleared.
  - DELAY=1: counter increments each cycle. On the edge where counter==STAGE_DELAY-1: clear oSTAGE_RESET[k], clear counter, go to WAIT_ACK.
    - Stage k therefore deasserts exactly STAGE_DELAY edges after the edge that left HOLD or the previous WAIT_ACK.
  - WAIT_ACK=2: when iSTAGE_ACK[k]=1 is sampled:
    - if k==NUM_STAGES-1, go to RUN;
    - otherwise k<=k+1, counter<=0, go to DELAY.
    - If the counter reaches ACK_TIMEOUT-1 with no ack, go to FAULT.
  - RUN=3: oALL_READY=1, registered, asserted the edge after the last ack is sampled.
  - FAULT=4: oFAULT=1, all oSTAGE_RESET reasserted, oALL_READY=0. Leave FAULT only via iRST, or a button press followed by release (which passes through HOLD).
- Global abort: from any state, iPOR_DONE=0 or btn_held=1 sampled produces the following on the next edge:
  - state HOLD, all oSTAGE_RESET=1, oALL_READY=0, k=0, counter=0;
  - oFAULT is cleared only by a button-initiated abort.
  - Abort takes priority over every other transition in the same cycle, including an ack arriving on the same edge.
- Released stages stay released while later stages sequence. Reassertion is always all stages together, never partial.
- Acks from stages other than k are ignored.
- If iSTAGE_ACK[k] is already 1 when stage k is released, WAIT_ACK lasts exactly one cycle.
- Counter saturates and never wraps.
- iRST mid-sequence: the next edge restores the full reset state above.

Test Plan:
Use STAGE_DELAY=4, DEBOUNCE=3, ACK_TIMEOUT=8, NUM_STAGES=3.
1. Nominal power-up:
   - Stimulus: iRST pulse; iPOR_DONE 0 for 10 cycles, then 1. Each ack is driven 2 cycles after its stage releases.
   - Required: oSTAGE_RESET goes 111→110→100→000. Stage 0 releases 4 edges after POR_DONE is sampled; each later stage 4 edges after the previous ack. oALL_READY=1 one edge after ack[2].
2. Pre-asserted acks:
   - Stimulus: iSTAGE_ACK=111 throughout.
   - Required: consecutive releases spaced exactly 5 edges (4 DELAY + 1 WAIT_ACK); oALL_READY high 15 edges after leaving HOLD.
3. Timeout:
   - Stimulus: never assert ack[1].
   - Required: 8 cycles after stage 1 releases, oFAULT=1, oSTAGE_RESET=111, oSTATE=4. State persists indefinitely with no button activity.
4. Button press in RUN:
   - Stimulus: iKEY_N low for 2 cycles (bounce), then low for 20 cycles.
   - Required: the 2-cycle glitch is ignored. Reset reasserts 2+3 synchronizer/debounce cycles plus 1 edge after the sustained low begins. Resequencing starts only after the debounced release.
5. POR drop during WAIT_ACK, coincident with ack[k]:
   - Stimulus: iPOR_DONE drops on the same edge that ack[k] is sampled.
   - Required: abort wins; state HOLD, all resets 1, k back to 0.
6. Fault recovery:
   - Stimulus: from FAULT, a debounced button press then release with iPOR_DONE=1.
   - Required: oFAULT clears on entry to HOLD; the full sequence from scenario 1 completes.
